// File: rtl/hac_4ph_sink.sv
// hac_4ph_sink: 4-phase bundled-data receiver that queues captured words in a FIFO.
// Defining HAC_4PH_SINK_TIMEOUT_EN adds a sticky err flag for a sender that never drops req.
module hac_4ph_sink #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  input  logic [WIDTH-1:0] data,
  output logic             ack,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef HAC_4PH_SINK_TIMEOUT_EN
  ,
  output logic             err
`endif
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, ACK_HI, RTZ} state_t;
  state_t state, state_nx;
  logic [SYNC_STAGES-1:0] sync;
  logic [AW-1:0] wptr, rptr;
  logic [AW:0] count;
  logic [WIDTH-1:0] mem [DEPTH];
  logic req_s, full, push, pop;
  if (SYNC_STAGES < 2 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1 || TIMEOUT > 255)
    $error("hac_4ph_sink: illegal parameter set");
  assign req_s = sync[SYNC_STAGES-1];
  assign full = count == (AW+1)'(DEPTH);
  assign out_valid = count != '0;
  assign out_data = mem[rptr];
  assign pop = out_valid && out_ready;
  // Full blocks capture even if a pop frees a slot on the same edge.
  assign push = state == IDLE && req_s && !full;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = push ? ACK_HI : IDLE;
      ACK_HI:  state_nx = req_s ? ACK_HI : RTZ;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync  <= '0;
      state <= IDLE;
      ack   <= 1'b0;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      sync  <= {sync[SYNC_STAGES-2:0], req};
      state <= state_nx;
      ack   <= state_nx == ACK_HI;
      if (push) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      if (push && !pop) count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  always_ff @(posedge clk)
    if (push) mem[wptr] <= data;
`ifdef HAC_4PH_SINK_TIMEOUT_EN
  logic [7:0] tcnt;
  // err rises on the edge where tcnt reaches TIMEOUT; the handshake itself is unaffected.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tcnt <= '0;
      err  <= 1'b0;
    end else begin
      if (push) tcnt <= '0;
      else if (state == ACK_HI && tcnt != 8'hFF) tcnt <= tcnt + 1'b1;
      if (state == ACK_HI && tcnt + 8'd1 == 8'(TIMEOUT)) err <= 1'b1;
    end
`endif
endmodule

// File: tb/tb_hac_4ph_sink.sv
// tb_hac_4ph_sink: directed handshake, fill, push/pop, reset and wrap vectors.
module tb_hac_4ph_sink;
  logic clk = 1'b0, rst_n = 1'b0, req = 1'b0, out_ready = 1'b0;
  logic [7:0] data = '0, out_data;
  logic ack, out_valid;
  int n_cmp = 0, n_bad = 0;
  logic [7:0] exp_q [$];
`ifdef HAC_4PH_SINK_TIMEOUT_EN
  logic err;
`endif
  hac_4ph_sink #(.WIDTH(8), .DEPTH(4), .SYNC_STAGES(2), .TIMEOUT(10)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .data(data), .ack(ack),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef HAC_4PH_SINK_TIMEOUT_EN
    , .err(err)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // Every word leaving the FIFO must match the oldest word sent.
  always @(negedge clk)
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("pop_unexpected", 32'(exp_q.size()), 1);
      else chk("pop_order", out_data, exp_q.pop_front());
    end
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic wait_ack(input logic v, input int max, input string tag);
    for (int i = 0; i < max; i++) begin
      step(1);
      if (ack == v) break;
    end
    chk(tag, ack, v);
  endtask
  task automatic send(input logic [7:0] w);
    data = w;
    req = 1'b1;
    exp_q.push_back(w);
    wait_ack(1'b1, 20, "send_ack_rise");
    req = 1'b0;
    wait_ack(1'b0, 20, "send_ack_fall");
  endtask
  initial begin
    #3;
    chk("rst_ack", ack, 0);
    chk("rst_valid", out_valid, 0);
`ifdef HAC_4PH_SINK_TIMEOUT_EN
    chk("rst_err", err, 0);
`endif
    step(2);
    rst_n = 1'b1;
    step(2);
    // single handshake with latency checks
    data = 8'hA5;
    req = 1'b1;
    exp_q.push_back(8'hA5);
    step(2);
    chk("rise_lat_early", ack, 0);
    step(1);
    chk("rise_lat", ack, 1);
    chk("single_valid", out_valid, 1);
    chk("single_data", out_data, 8'hA5);
    req = 1'b0;
    step(2);
    chk("fall_lat_early", ack, 1);
    step(1);
    chk("fall_lat", ack, 0);
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    chk("single_drained", out_valid, 0);
    // fill to DEPTH, fifth word must stall
    for (int i = 1; i <= 4; i++) send(8'(i));
    data = 8'h05;
    req = 1'b1;
    exp_q.push_back(8'h05);
    step(10);
    chk("full_hold_ack", ack, 0);
    chk("full_head", out_data, 8'h01);
    out_ready = 1'b1;
    wait_ack(1'b1, 20, "full_ack5_rise");
    req = 1'b0;
    wait_ack(1'b0, 20, "full_ack5_fall");
    step(4);
    chk("full_drained", out_valid, 0);
    chk("full_q_empty", 32'(exp_q.size()), 0);
    out_ready = 1'b0;
    // simultaneous push and pop
    send(8'hA1);
    send(8'hA2);
    data = 8'h3C;
    req = 1'b1;
    exp_q.push_back(8'h3C);
    step(2);
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    chk("pp_ack", ack, 1);
    chk("pp_valid", out_valid, 1);
    chk("pp_head", out_data, 8'hA2);
    req = 1'b0;
    wait_ack(1'b0, 20, "pp_ack_fall");
    out_ready = 1'b1;
    step(2);
    chk("pp_two_left", 32'(exp_q.size()), 0);
    chk("pp_drained", out_valid, 0);
    out_ready = 1'b0;
    // reset mid-handshake
    data = 8'h5A;
    req = 1'b1;
    wait_ack(1'b1, 20, "mid_ack_rise");
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_ack", ack, 0);
    chk("mid_rst_valid", out_valid, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    exp_q.push_back(8'h5A);
    step(2);
    chk("recap_early", ack, 0);
    step(1);
    chk("recap_ack", ack, 1);
    chk("recap_data", out_data, 8'h5A);
    req = 1'b0;
    wait_ack(1'b0, 20, "recap_ack_fall");
    out_ready = 1'b1;
    step(3);
    chk("recap_drained", out_valid, 0);
    // wrap pointers twice with streaming drain
    for (int i = 0; i < 10; i++) send(8'h10 + 8'(i));
    step(3);
    chk("wrap_q_empty", 32'(exp_q.size()), 0);
    chk("wrap_drained", out_valid, 0);
`ifdef HAC_4PH_SINK_TIMEOUT_EN
    data = 8'h77;
    req = 1'b1;
    exp_q.push_back(8'h77);
    wait_ack(1'b1, 20, "to_ack_rise");
    step(9);
    chk("to_err_early", err, 0);
    step(1);
    chk("to_err_set", err, 1);
    req = 1'b0;
    wait_ack(1'b0, 20, "to_ack_fall");
    step(3);
    chk("to_err_sticky", err, 1);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
